// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU sharing controller: ALUCtrl codes and FSM states.
// The helper isIllegalCtrl is only used when ALU_SHARE_ILLEGAL_OP_CHECK_EN is defined.
package alu_share_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SLL  = 4'b0011;
   localparam logic [3:0] ALU_SRL  = 4'b0100;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_ADDU = 4'b1000;
   localparam logic [3:0] ALU_SUBU = 4'b1001;
   localparam logic [3:0] ALU_XOR  = 4'b1010;
   localparam logic [3:0] ALU_SLTU = 4'b1011;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_LUI  = 4'b1110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // 0101 and 1111 are the two codes the ALU does not implement.
   function automatic logic isIllegalCtrl(input logic [3:0] code);
      return (code == 4'b0101) || (code == 4'b1111);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone valid requester wins, a tie goes to the
// requester that was not granted last. Purely combinational, grants are one-hot or zero.
module rr_arb2 (
   input  logic valid0,
   input  logic valid1,
   input  logic lastGrant,
   output logic gnt0,
   output logic gnt1
);

   assign gnt0 = valid0 & (~valid1 | lastGrant);
   assign gnt1 = valid1 & (~valid0 | ~lastGrant);

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two requesters: round-robin accept, hold operands for a settle
// window, capture BusW/Zero, return with owner ID. Option: ALU_SHARE_ILLEGAL_OP_CHECK_EN.
module alu_share_ctrl
   import alu_share_pkg::*;
#(
   parameter int N             = 32,
   parameter int SETTLE_CYCLES = 3
) (
   input  logic         CLK,
   input  logic         Reset_L,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic [3:0]   req0_ctrl,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   input  logic [3:0]   req1_ctrl,
   output logic [N-1:0] alu_busa,
   output logic [N-1:0] alu_busb,
   output logic [3:0]   alu_ctrl,
   input  logic [N-1:0] alu_busw,
   input  logic         alu_zero,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [N-1:0] rsp_result,
   output logic         rsp_zero,
   output logic         rsp_err,
   output state_t       dbgState
);

   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic           lastGrant;
   logic           gnt0;
   logic           gnt1;
   logic           accept;
   logic           selId;
   logic [N-1:0]   selA;
   logic [N-1:0]   selB;
   logic [3:0]     selCtrl;

   rr_arb2 uArb (
      .valid0    (req0_valid),
      .valid1    (req1_valid),
      .lastGrant (lastGrant),
      .gnt0      (gnt0),
      .gnt1      (gnt1)
   );

   // Handshake rule: an op transfers on a rising edge where reqX_valid and reqX_ready are
   // both high; a result transfers where rsp_valid and rsp_ready are both high.
   assign req0_ready = (state == ST_IDLE) & gnt0;
   assign req1_ready = (state == ST_IDLE) & gnt1;
   assign accept     = req0_ready | req1_ready;
   assign selId      = gnt1;
   assign selA       = gnt1 ? req1_a    : req0_a;
   assign selB       = gnt1 ? req1_b    : req0_b;
   assign selCtrl    = gnt1 ? req1_ctrl : req0_ctrl;
   assign dbgState   = state;

`ifndef ALU_SHARE_ILLEGAL_OP_CHECK_EN
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         lastGrant  <= 1'b1;
         alu_busa   <= '0;
         alu_busb   <= '0;
         alu_ctrl   <= ALU_AND;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
`ifdef ALU_SHARE_ILLEGAL_OP_CHECK_EN
         rsp_err    <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  rsp_id    <= selId;
                  lastGrant <= selId;
`ifdef ALU_SHARE_ILLEGAL_OP_CHECK_EN
                  if (isIllegalCtrl(selCtrl)) begin
                     // Undefined code: answer at once and leave the ALU inputs untouched.
                     rsp_result <= '0;
                     rsp_zero   <= 1'b0;
                     rsp_err    <= 1'b1;
                     rsp_valid  <= 1'b1;
                     state      <= ST_RESP;
                  end else begin
                     alu_busa <= selA;
                     alu_busb <= selB;
                     alu_ctrl <= selCtrl;
                     cnt      <= CW'(SETTLE_CYCLES - 1);
                     rsp_err  <= 1'b0;
                     state    <= ST_WAIT;
                  end
`else
                  alu_busa <= selA;
                  alu_busb <= selB;
                  alu_ctrl <= selCtrl;
                  cnt      <= CW'(SETTLE_CYCLES - 1);
                  state    <= ST_WAIT;
`endif
               end
            end
            ST_WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  rsp_result <= alu_busw;
                  rsp_zero   <= alu_zero;
                  rsp_valid  <= 1'b1;
                  state      <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
